sha2_stream_engine: RTL
=======================

// Module: sha2_stream_engine
// PURPOSE
//  Parametrised successor engine for SHA-224/SHA-256. Message blocks arrive as 16 big-endian
//  32-bit words over a valid/ready stream (normally from the 32-bit PL FIFO), and multi-block
//  messages are chained until the word tagged last. Runs UNROLL compression rounds per clock
//  and holds a 16-word rolling schedule window instead of a 64-word W array.
//  Sits between the AXI-register input FIFO and the result registers of the hashing regs block.
// PARAMETERS
//  UNROLL    1   rounds per clock; legal 1,2,4 (64 divisible); other values -> $error at elab
//  CNT_W     32  width of the processed-block counter
// PORTS
//  clk        in   1      system clock
//  rst        in   1      asynchronous reset, active-high
//  start_i    in   1      pulse: begin new message, load IV per mode_224_i; ignored unless ready_o
//  mode_224_i in   1      0=SHA-256, 1=SHA-224; sampled only on accepted start_i
//  s_valid_i  in   1      input word valid
//  s_ready_o  out  1      engine accepts word (LOAD state only)
//  s_data_i   in   32     message word, big-endian, already padded by software
//  s_last_i   in   1      qualifies the final word of the final block
//  ready_o    out  1      idle, start_i accepted
//  valid_o    out  1      hash_o holds final digest; cleared by next accepted start_i
//  err_o      out  1      sticky: s_last_i seen on word index != 15; cleared by start_i
//  hash_o     out  256    digest H0..H7 (H0 in [255:224]); SHA-224: H0..H6, [31:0]=0
//  blocks_o   out  CNT_W  blocks compressed since start_i, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, ready_o=1, s_ready_o=0, valid_o=0, err_o=0,
//   hash_o=0, blocks_o=0, word/round counters=0. No partial result survives reset.
//  States: IDLE -> LOAD -> ROUND -> UPDATE -> (LOAD | DONE); DONE behaves as IDLE with valid_o=1.
//  IDLE/DONE: ready_o=1. start_i: H<=IV(mode), valid_o<=0, err_o<=0, blocks_o<=0, -> LOAD next clk.
//  LOAD: s_ready_o=1; a word transfers when s_valid_i&&s_ready_o. Word n (0..15) -> window[n].
//   After word 15: a..h<=H, round=0, -> ROUND. Bubbles on s_valid_i add cycles, no data loss.
//   s_last_i on word<15: err_o<=1, word is still stored, load continues, last flag is ignored.
//   s_last_i on word 15: latch last_blk=1.
//  ROUND: per clk run UNROLL chained rounds t..t+UNROLL-1. W[t]=window[0] for t<16, otherwise
//   sigma1(W[t-2])+W[t-7]+sigma0(W[t-15])+W[t-16]. Window shifts one word per round.
//   All adds mod 2^32. Duration exactly 64/UNROLL clks.
//  UPDATE (1 clk): H[i]<=H[i]+{a..h}[i] mod 2^32; blocks_o<=blocks_o+1.
//   If last_blk, -> DONE with valid_o=1 on the same edge. Otherwise -> LOAD.
//  Latency per block: 16 transfer clks + 64/UNROLL + 1; last word accepted -> valid_o in 64/UNROLL+1 clks.
//  hash_o is updated only at UPDATE of the last block; it is stable while valid_o=1.
//  start_i outside IDLE/DONE is ignored. start_i with s_valid_i in the same clk: word not taken
//   (s_ready_o=0 that clk).
//  IV256 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
//  IV224 c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4.
//  K[0..63] per FIPS 180-4, held in a combinational ROM indexed by the round counter.
// TESTING
//  T1 SHA-256 "abc": one padded block (61626380,0..,00000018 last) -> valid_o, hash_o=
//     ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, blocks_o=1
//  T2 SHA-224 "abc": same block, mode_224_i=1 -> hash_o[255:32]=
//     23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, [31:0]=0
//  T3 two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> 248d6a61d20638b8
//     e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, blocks_o=2
//  T4 empty msg (80000000,0..0) with random s_valid_i gaps, each UNROLL in {1,2,4} ->
//     e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855; exact latency 64/UNROLL+1
//  T5 s_last_i on word 7 -> err_o=1, no valid_o after that block; next start_i clears err_o
//  T6 rst asserted mid-ROUND -> all outputs at reset values; T1 rerun afterwards gives correct hash

Source files
------------

// File: rtl/sha2_stream_engine.sv
// SHA-224/SHA-256 streaming engine: loads 16-word blocks over valid/ready, runs UNROLL
// rounds per clock over a rolling 16-word schedule window and chains blocks until last.
module sha2_stream_engine #(
    parameter int UNROLL = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             mode_224_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [31:0]      s_data_i,
    input  logic             s_last_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic             err_o,
    output logic [255:0]     hash_o,
    output logic [CNT_W-1:0] blocks_o
);

    generate
        if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
            $error("sha2_stream_engine: UNROLL must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_UPDATE, S_DONE} state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] k_rom(input logic [5:0] idx);
        return K_TAB[idx];
    endfunction

    state_t      state;
    logic [3:0]  wcnt;
    logic [5:0]  rnd;
    logic        last_blk;
    logic        mode;
    logic [31:0] hs  [8];
    logic [31:0] wv  [8];
    logic [31:0] win [16];

    logic [31:0] win_s [UNROLL+1][16];
    logic [31:0] var_s [UNROLL+1][8];
    logic [31:0] t1_s  [UNROLL];
    logic [31:0] t2_s  [UNROLL];
    logic [31:0] hsum  [8];
    logic [255:0] digest;
    logic        take;

    assign take = s_valid_i && s_ready_o;

    // UNROLL chained rounds; window[0] is always W[t], and W[t+16] is shifted in behind it
    always_comb begin
        win_s[0] = win;
        var_s[0] = wv;
        for (int j = 0; j < UNROLL; j++) begin
            t1_s[j] = var_s[j][7] + big_s1(var_s[j][4])
                    + ((var_s[j][4] & var_s[j][5]) ^ (~var_s[j][4] & var_s[j][6]))
                    + k_rom(rnd + 6'(j)) + win_s[j][0];
            t2_s[j] = big_s0(var_s[j][0])
                    + ((var_s[j][0] & var_s[j][1]) ^ (var_s[j][0] & var_s[j][2]) ^ (var_s[j][1] & var_s[j][2]));
            var_s[j+1][0] = t1_s[j] + t2_s[j];
            var_s[j+1][1] = var_s[j][0];
            var_s[j+1][2] = var_s[j][1];
            var_s[j+1][3] = var_s[j][2];
            var_s[j+1][4] = var_s[j][3] + t1_s[j];
            var_s[j+1][5] = var_s[j][4];
            var_s[j+1][6] = var_s[j][5];
            var_s[j+1][7] = var_s[j][6];
            for (int i = 0; i < 15; i++) begin
                win_s[j+1][i] = win_s[j][i+1];
            end
            win_s[j+1][15] = small_s1(win_s[j][14]) + win_s[j][9] + small_s0(win_s[j][1]) + win_s[j][0];
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            hsum[i] = hs[i] + wv[i];
        end
        digest = {hsum[0], hsum[1], hsum[2], hsum[3], hsum[4], hsum[5], hsum[6], hsum[7]};
        if (mode) begin
            digest[31:0] = '0;
        end
    end

    // Message window and working variables carry no reset; they are always reloaded before use
    always_ff @(posedge clk) begin
        if (state == S_LOAD && take) begin
            win[wcnt] <= s_data_i;
            if (wcnt == 4'd15) begin
                wv <= hs;
            end
        end
        if (state == S_ROUND) begin
            win <= win_s[UNROLL];
            wv  <= var_s[UNROLL];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ready_o   <= 1'b1;
            s_ready_o <= 1'b0;
            valid_o   <= 1'b0;
            err_o     <= 1'b0;
            hash_o    <= '0;
            blocks_o  <= '0;
            wcnt      <= '0;
            rnd       <= '0;
            last_blk  <= 1'b0;
            mode      <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                hs[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        for (int i = 0; i < 8; i++) begin
                            hs[i] <= mode_224_i ? IV224[i] : IV256[i];
                        end
                        mode      <= mode_224_i;
                        valid_o   <= 1'b0;
                        err_o     <= 1'b0;
                        blocks_o  <= '0;
                        wcnt      <= '0;
                        last_blk  <= 1'b0;
                        ready_o   <= 1'b0;
                        s_ready_o <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (take) begin
                        wcnt <= wcnt + 4'd1;
                        if (s_last_i) begin
                            if (wcnt == 4'd15) last_blk <= 1'b1;
                            else               err_o    <= 1'b1;
                        end
                        if (wcnt == 4'd15) begin
                            rnd       <= '0;
                            s_ready_o <= 1'b0;
                            state     <= S_ROUND;
                        end
                    end
                end
                S_ROUND: begin
                    rnd <= rnd + 6'(UNROLL);
                    if (rnd == 6'(64 - UNROLL)) begin
                        state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    for (int i = 0; i < 8; i++) begin
                        hs[i] <= hsum[i];
                    end
                    blocks_o <= blocks_o + CNT_W'(1);
                    if (last_blk) begin
                        hash_o  <= digest;
                        valid_o <= 1'b1;
                        ready_o <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        s_ready_o <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule
